// File: rtl/mtimer_irq_ctrl_if.sv
// Data-memory bus slave port for the machine timer / interrupt front end.
//   bus_req   : access strobe, already address-decoded for this block
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : byte address (only [4:2] decoded by the slave)
//   bus_wdata : full-word write data
//   bus_rdata : read data, valid while bus_ack = 1, zero otherwise
//   bus_ack   : one-cycle completion pulse, one cycle after the request edge
interface mtimer_irq_ctrl_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mtimer_irq_ctrl.sv
// Machine timer and external-interrupt front end (CLINT-lite).
// Holds a 64-bit mtime/mtimecmp pair with a prescaler, a synchronised external
// interrupt line with edge-detected W1C pending bit, and drives one registered
// level interrupt towards the CSR unit (mip[11]).
//   clk           : clock
//   reset         : synchronous, active-high reset
//   bus           : data-memory bus slave port (req/we/addr/wdata -> rdata/ack)
//   ext_irq_async : asynchronous external interrupt request
//   irq_out       : registered level interrupt to the CSR unit
module mtimer_irq_ctrl #(
   parameter int unsigned PRESC_W  = 8,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic             clk,
   input  logic             reset,
   mtimer_irq_ctrl_if.slave bus,
   input  logic             ext_irq_async,
   output logic             irq_out
);

   localparam int unsigned TIME_W    = 64;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned PRESC_LSB = 8;

   localparam logic [2:0] REG_MTIME_LO = 3'd0;
   localparam logic [2:0] REG_MTIME_HI = 3'd1;
   localparam logic [2:0] REG_CMP_LO   = 3'd2;
   localparam logic [2:0] REG_CMP_HI   = 3'd3;
   localparam logic [2:0] REG_CTRL     = 3'd4;
   localparam logic [2:0] REG_STATUS   = 3'd5;

   logic [TIME_W-1:0]   mtime;
   logic [TIME_W-1:0]   mtimecmp;
   logic                ctrl_en;
   logic                ctrl_tie;
   logic                ctrl_eie;
   logic [PRESC_W-1:0]  ctrl_presc;
   logic [PRESC_W-1:0]  presc_cnt;
   logic                timer_pend;
   logic                ext_pend;
   logic [SYNC_STG-1:0] sync_q;
   logic                ext_prev;

   logic [2:0]          reg_sel;
   logic                wr_en;
   logic                wr_mtime_lo;
   logic                wr_mtime_hi;
   logic                time_tick;
   logic                ext_rise;
   logic                ext_clr;
   logic [DATA_W-1:0]   rd_data;
   logic                unused_addr_bits;

   assign reg_sel          = bus.bus_addr[4:2];
   assign unused_addr_bits = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};

   assign wr_en       = bus.bus_req & bus.bus_we;
   assign wr_mtime_lo = wr_en && (reg_sel == REG_MTIME_LO);
   assign wr_mtime_hi = wr_en && (reg_sel == REG_MTIME_HI);
   assign time_tick   = ctrl_en && (presc_cnt == ctrl_presc);
   assign ext_rise    = sync_q[SYNC_STG-1] & ~ext_prev;
   assign ext_clr     = wr_en && (reg_sel == REG_STATUS) && bus.bus_wdata[1];

   // Read mux over the pre-edge register values.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_MTIME_LO: rd_data = mtime[31:0];
         REG_MTIME_HI: rd_data = mtime[63:32];
         REG_CMP_LO:   rd_data = mtimecmp[31:0];
         REG_CMP_HI:   rd_data = mtimecmp[63:32];
         REG_CTRL: begin
            rd_data[0]                   = ctrl_en;
            rd_data[1]                   = ctrl_tie;
            rd_data[2]                   = ctrl_eie;
            rd_data[PRESC_LSB +: PRESC_W] = ctrl_presc;
         end
         REG_STATUS: rd_data[1:0] = {ext_pend, timer_pend};
         default:    rd_data = '0;
      endcase
   end

   // Bus response: single-cycle ack, read data only during a read ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.bus_ack   <= 1'b0;
         bus.bus_rdata <= '0;
      end else begin
         bus.bus_ack   <= bus.bus_req;
         bus.bus_rdata <= (bus.bus_req && !bus.bus_we) ? rd_data : '0;
      end
   end

   // Control and compare registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_en    <= 1'b0;
         ctrl_tie   <= 1'b0;
         ctrl_eie   <= 1'b0;
         ctrl_presc <= '0;
         mtimecmp   <= '1;
      end else if (wr_en) begin
         case (reg_sel)
            REG_CMP_LO: mtimecmp[31:0]  <= bus.bus_wdata;
            REG_CMP_HI: mtimecmp[63:32] <= bus.bus_wdata;
            REG_CTRL: begin
               ctrl_en    <= bus.bus_wdata[0];
               ctrl_tie   <= bus.bus_wdata[1];
               ctrl_eie   <= bus.bus_wdata[2];
               ctrl_presc <= bus.bus_wdata[PRESC_LSB +: PRESC_W];
            end
            default: ;
         endcase
      end
   end

   // Prescaler and mtime; a software write to either half suppresses that cycle's tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_cnt <= '0;
         mtime     <= '0;
      end else begin
         if (ctrl_en)
            presc_cnt <= (presc_cnt == ctrl_presc) ? '0 : presc_cnt + PRESC_W'(1);
         if (wr_mtime_lo)
            mtime[31:0] <= bus.bus_wdata;
         else if (wr_mtime_hi)
            mtime[63:32] <= bus.bus_wdata;
         else if (time_tick)
            mtime <= mtime + TIME_W'(1);
      end
   end

   // Pending bits and the registered interrupt level; ext set beats W1C clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         ext_prev   <= 1'b0;
         ext_pend   <= 1'b0;
         timer_pend <= 1'b0;
         irq_out    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STG-2:0], ext_irq_async};
         ext_prev   <= sync_q[SYNC_STG-1];
         ext_pend   <= ext_rise | (ext_pend & ~ext_clr);
         timer_pend <= (mtime >= mtimecmp);
         irq_out    <= (timer_pend & ctrl_tie) | (ext_pend & ctrl_eie);
      end
   end

endmodule

// File: tb/tb_mtimer_irq_ctrl.sv
// Self-checking bench for mtimer_irq_ctrl: directed timing scenarios followed by
// randomized prescaler/compare rounds checked against a closed-form model.
module tb_mtimer_irq_ctrl;

   localparam logic [31:0] A_MLO  = 32'h00;
   localparam logic [31:0] A_MHI  = 32'h04;
   localparam logic [31:0] A_CLO  = 32'h08;
   localparam logic [31:0] A_CHI  = 32'h0C;
   localparam logic [31:0] A_CTRL = 32'h10;
   localparam logic [31:0] A_STAT = 32'h14;
   localparam logic [31:0] A_RSV  = 32'h1C;

   logic clk;
   logic reset;
   logic ext_irq_async;
   logic irq_out;
   int   n_cmp;
   int   n_err;

   mtimer_irq_ctrl_if bus_if ();

   mtimer_irq_ctrl #(.PRESC_W(8), .SYNC_STG(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus_if),
      .ext_irq_async (ext_irq_async),
      .irq_out       (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // All steps start and end on a falling edge; each tick passes one rising edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.bus_req   = 1'b1;
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = d;
      tick(1);
      chk("wr_ack", 64'(bus_if.bus_ack), 64'd1);
      bus_if.bus_req = 1'b0;
      bus_if.bus_we  = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      bus_if.bus_req  = 1'b1;
      bus_if.bus_we   = 1'b0;
      bus_if.bus_addr = a;
      tick(1);
      chk("rd_ack", 64'(bus_if.bus_ack), 64'd1);
      d = bus_if.bus_rdata;
      bus_if.bus_req = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      chk(tag, 64'(d), 64'(exp));
   endtask

   logic [63:0] m_start;
   logic [63:0] m_cmp;
   logic [63:0] m_time;
   logic [31:0] rlo;
   logic [31:0] rhi;
   logic [31:0] rst_v;
   int          p;
   int          n;

   initial begin
      n_cmp            = 0;
      n_err            = 0;
      reset            = 1'b1;
      ext_irq_async    = 1'b0;
      bus_if.bus_req   = 1'b0;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = '0;
      bus_if.bus_wdata = '0;
      tick(3);
      reset = 1'b0;

      // T1: reset state and basic reads
      chk("t1_irq", 64'(irq_out), 64'd0);
      chk("t1_ack", 64'(bus_if.bus_ack), 64'd0);
      rd_chk("t1_cmp_lo", A_CLO, 32'hFFFF_FFFF);
      tick(1);
      chk("t1_ack_one_cycle", 64'(bus_if.bus_ack), 64'd0);
      chk("t1_rdata_idle", 64'(bus_if.bus_rdata), 64'd0);
      rd_chk("t1_cmp_hi", A_CHI, 32'hFFFF_FFFF);
      rd_chk("t1_rsv", A_RSV, 32'h0);
      rd_chk("t1_mtime", A_MLO, 32'h0);
      rd_chk("t1_ctrl", A_CTRL, 32'h0);

      // T2: presc=0 counting and timer interrupt timing
      bus_wr(A_CLO, 32'd10);
      bus_wr(A_CHI, 32'd0);
      bus_wr(A_CTRL, 32'h3);
      for (int i = 0; i < 5; i++) rd_chk("t2_seq", A_MLO, 32'(i));
      tick(6);
      chk("t2_irq_before", 64'(irq_out), 64'd0);
      tick(1);
      chk("t2_irq_rise", 64'(irq_out), 64'd1);
      bus_wr(A_CLO, 32'd100);
      chk("t2_irq_hold0", 64'(irq_out), 64'd1);
      tick(1);
      chk("t2_irq_hold1", 64'(irq_out), 64'd1);
      tick(1);
      chk("t2_irq_fall", 64'(irq_out), 64'd0);

      // T3: presc=3, then freeze and resume
      rst_pulse();
      bus_wr(A_CTRL, 32'h301);
      for (int i = 0; i < 9; i++) rd_chk("t3_presc", A_MLO, 32'(i / 4));
      bus_wr(A_CTRL, 32'h300);
      tick(7);
      rd_chk("t3_frozen", A_MLO, 32'd2);
      bus_wr(A_CTRL, 32'h301);
      rd_chk("t3_resume0", A_MLO, 32'd2);
      rd_chk("t3_resume1", A_MLO, 32'd2);
      rd_chk("t3_resume2", A_MLO, 32'd3);

      // T4: carry, wrap and write/increment collision
      rst_pulse();
      bus_wr(A_MHI, 32'h0);
      bus_wr(A_MLO, 32'hFFFF_FFFF);
      bus_wr(A_CTRL, 32'h1);
      bus_wr(A_CTRL, 32'h0);
      rd_chk("t4_carry_hi", A_MHI, 32'h1);
      rd_chk("t4_carry_lo", A_MLO, 32'h0);
      bus_wr(A_MHI, 32'hFFFF_FFFF);
      bus_wr(A_MLO, 32'hFFFF_FFFF);
      bus_wr(A_CTRL, 32'h1);
      bus_wr(A_CTRL, 32'h0);
      rd_chk("t4_wrap_lo", A_MLO, 32'h0);
      rd_chk("t4_wrap_hi", A_MHI, 32'h0);
      bus_wr(A_CTRL, 32'h1);
      bus_wr(A_MLO, 32'h1234_5678);
      rd_chk("t4_coinc_lo", A_MLO, 32'h1234_5678);
      rd_chk("t4_coinc_hi", A_MHI, 32'h0);
      bus_wr(A_CTRL, 32'h0);

      // T5: external interrupt path
      rst_pulse();
      bus_wr(A_CTRL, 32'h4);
      ext_irq_async = 1'b1;
      tick(1);
      tick(2);
      chk("t5_irq_early", 64'(irq_out), 64'd0);
      tick(1);
      chk("t5_irq_rise", 64'(irq_out), 64'd1);
      tick(1);
      ext_irq_async = 1'b0;
      tick(4);
      rd_chk("t5_status", A_STAT, 32'h2);
      bus_wr(A_STAT, 32'h2);
      chk("t5_irq_hold", 64'(irq_out), 64'd1);
      tick(1);
      chk("t5_irq_fall", 64'(irq_out), 64'd0);
      rd_chk("t5_status_clr", A_STAT, 32'h0);
      tick(3);
      ext_irq_async = 1'b1;
      tick(2);
      bus_wr(A_STAT, 32'h2);
      rd_chk("t5_set_wins", A_STAT, 32'h2);
      chk("t5_set_wins_irq", 64'(irq_out), 64'd1);
      ext_irq_async = 1'b0;

      // T6: reset during activity
      bus_wr(A_CTRL, 32'h5);
      tick(3);
      chk("t6_irq_pre", 64'(irq_out), 64'd1);
      bus_if.bus_req  = 1'b1;
      bus_if.bus_we   = 1'b0;
      bus_if.bus_addr = A_MLO;
      tick(1);
      chk("t6_ack_pre", 64'(bus_if.bus_ack), 64'd1);
      reset = 1'b1;
      tick(1);
      chk("t6_ack", 64'(bus_if.bus_ack), 64'd0);
      chk("t6_rdata", 64'(bus_if.bus_rdata), 64'd0);
      chk("t6_irq", 64'(irq_out), 64'd0);
      reset          = 1'b0;
      bus_if.bus_req = 1'b0;
      rd_chk("t6_mtime_lo", A_MLO, 32'h0);
      rd_chk("t6_mtime_hi", A_MHI, 32'h0);
      rd_chk("t6_cmp_lo", A_CLO, 32'hFFFF_FFFF);
      rd_chk("t6_cmp_hi", A_CHI, 32'hFFFF_FFFF);
      rd_chk("t6_status", A_STAT, 32'h0);

      // Random rounds: after n enabled cycles from a clean prescaler,
      // mtime = start + floor(n / (presc + 1)), pend = mtime >= cmp.
      for (int r = 0; r < 24; r++) begin
         rst_pulse();
         p = int'($urandom_range(0, 7));
         n = int'($urandom_range(1, 40));
         rhi = $urandom();
         rlo = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom();
         m_start = {rhi, rlo};
         m_cmp   = m_start + 64'($urandom_range(0, 12));
         m_time  = m_start + 64'(n / (p + 1));
         bus_wr(A_MLO, m_start[31:0]);
         bus_wr(A_MHI, m_start[63:32]);
         bus_wr(A_CLO, m_cmp[31:0]);
         bus_wr(A_CHI, m_cmp[63:32]);
         bus_wr(A_CTRL, 32'h3 | (32'(p) << 8));
         tick(n - 1);
         bus_wr(A_CTRL, 32'h2 | (32'(p) << 8));
         bus_rd(A_MLO, rlo);
         bus_rd(A_MHI, rhi);
         chk("rnd_mtime", {rhi, rlo}, m_time);
         bus_rd(A_STAT, rst_v);
         chk("rnd_status", 64'(rst_v), (m_time >= m_cmp) ? 64'd1 : 64'd0);
         chk("rnd_irq", 64'(irq_out), (m_time >= m_cmp) ? 64'd1 : 64'd0);
         tick(1);
         chk("rnd_rdata_idle", 64'(bus_if.bus_rdata), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
